// File: rtl/adder_core.sv
// adder_core: registered unsigned adder/subtractor with a valid handshake.
// The result is WIDTH+1 bits wide, so its MSB carries the carry-out on an add
// and the borrow on a subtract.
// Optional build macro: ADDER_CORE_PIPE2_EN adds an operand register stage,
// which makes the latency 2 cycles. Throughput stays at one result per cycle.
module adder_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   sum,
  output logic             out_valid,
  output logic             zero
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             op_valid;
  logic [WIDTH:0]   result;

`ifdef ADDER_CORE_PIPE2_EN
  // Operand stage: capture operands only when valid, so idle input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      op_sub   <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= in_valid;
      if (in_valid) begin
        op_a   <= a;
        op_b   <= b;
        op_sub <= sub;
      end
    end
  end
`else
  // Single-stage build: operands feed the arithmetic directly.
  always_comb begin
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    op_valid = in_valid;
  end
`endif

  // Zero-extended add/subtract; the subtract wraps modulo 2^(WIDTH+1).
  always_comb begin
    if (op_sub) begin
      result = {1'b0, op_a} - {1'b0, op_b};
    end else begin
      result = {1'b0, op_a} + {1'b0, op_b};
    end
  end

  // Result stage: sum and zero load together and hold while no valid data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b1;
    end else begin
      out_valid <= op_valid;
      if (op_valid) begin
        sum  <= result;
        zero <= (result == '0);
      end
    end
  end

endmodule

// File: tb/tb_adder_core.sv
// Bench for adder_core at WIDTH=4.
// Expected {zero,sum} pairs are queued as each input is driven. They are
// popped and compared whenever out_valid is seen.
module tb_adder_core;

`ifdef ADDER_CORE_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       sub;
  logic [4:0] sum;
  logic       out_valid;
  logic       zero;

  int total;
  int bad;
  logic [5:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [4:0] e;
  } vec_t;

  adder_core #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .sum      (sum),
    .out_valid(out_valid),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    int pulses;
    logic [5:0] e;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 4'($urandom);
      b = 4'($urandom);
      sub = 1'($urandom);
      total++;
      if (sum !== 5'd0 || out_valid !== 1'b0 || zero !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold: sum=%b out_valid=%b zero=%b, want 00000/0/1", sum, out_valid, zero);
      end
    end
    rst_n = 1'b1;
    a = 4'd0;
    b = 4'd0;
    sub = 1'b0;
    exp_q.push_back({1'b1, 5'd0});
    pulses = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a = 4'($urandom);
      if (out_valid === 1'b1) begin
        pulses++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL reset_first: unexpected out_valid sum=%b", sum);
        end else begin
          e = exp_q.pop_front();
          if ({zero, sum} !== e) begin
            bad++;
            $display("FAIL reset_first: zero,sum=%b want %b", {zero, sum}, e);
          end
        end
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL reset_first_pulse: out_valid cycles=%0d want 1", pulses);
    end
    exp_q.delete();
  endtask

  task automatic test_add();
    vec_t v[4];
    int first;
    int last;
    int cnt;
    logic [5:0] e;
    v[0] = '{4'd1,  4'd2, 1'b0, 5'b00011};
    v[1] = '{4'd7,  4'd1, 1'b0, 5'b01000};
    v[2] = '{4'd15, 4'd1, 1'b0, 5'b10000};
    v[3] = '{4'd10, 4'd5, 1'b0, 5'b01111};
    first = -1;
    last = -1;
    cnt = 0;
    for (int i = 0; i < 4 + LAT + 2; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL add: unexpected out_valid sum=%b", sum);
        end else begin
          e = exp_q.pop_front();
          if ({zero, sum} !== e) begin
            bad++;
            $display("FAIL add: zero,sum=%b want %b", {zero, sum}, e);
          end
        end
      end
      if (i < 4) begin
        in_valid = 1'b1;
        a = v[i].a;
        b = v[i].b;
        sub = v[i].s;
        exp_q.push_back({(v[i].e == 5'd0), v[i].e});
      end else begin
        in_valid = 1'b0;
      end
    end
    total++;
    if (cnt != 4 || last - first != 3) begin
      bad++;
      $display("FAIL add_b2b: valid cycles=%0d span=%0d want 4/3", cnt, last - first);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL add_drain: %0d results missing, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_sub();
    vec_t v[5];
    logic [5:0] e;
    v[0] = '{4'd7,  4'd1,  1'b1, 5'b00110};
    v[1] = '{4'd1,  4'd2,  1'b1, 5'b11111};
    v[2] = '{4'd9,  4'd9,  1'b1, 5'b00000};
    v[3] = '{4'd15, 4'd15, 1'b0, 5'b11110};
    v[4] = '{4'd0,  4'd15, 1'b1, 5'b10001};
    for (int i = 0; i < 5 + LAT + 2; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sub_ext: unexpected out_valid sum=%b", sum);
        end else begin
          e = exp_q.pop_front();
          if ({zero, sum} !== e) begin
            bad++;
            $display("FAIL sub_ext: zero,sum=%b want %b", {zero, sum}, e);
          end
        end
      end
      if (i < 5) begin
        in_valid = 1'b1;
        a = v[i].a;
        b = v[i].b;
        sub = v[i].s;
        exp_q.push_back({(v[i].e == 5'd0), v[i].e});
      end else begin
        in_valid = 1'b0;
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sub_drain: %0d results missing, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_hold();
    bit seen;
    int cnt;
    for (int i = 0; i < LAT + 7; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        cnt++;
        seen = 1'b1;
        total++;
        if (sum !== 5'b00111 || zero !== 1'b0) begin
          bad++;
          $display("FAIL hold_result: sum=%b zero=%b want 00111/0", sum, zero);
        end
      end else if (seen) begin
        total++;
        if (sum !== 5'b00111 || zero !== 1'b0) begin
          bad++;
          $display("FAIL hold_idle: sum=%b zero=%b want 00111/0", sum, zero);
        end
      end
      if (i == 0) begin
        in_valid = 1'b1;
        a = 4'd3;
        b = 4'd4;
        sub = 1'b0;
      end else begin
        in_valid = 1'b0;
        a = 4'd15;
        b = 4'd15;
        sub = 1'($urandom);
      end
    end
    total++;
    if (cnt != 1) begin
      bad++;
      $display("FAIL hold_pulse: out_valid cycles=%0d want 1", cnt);
    end
  endtask

  task automatic test_midreset();
    int stale;
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'd5;
    b = 4'd6;
    sub = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (sum !== 5'd0 || out_valid !== 1'b0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL midreset_async: sum=%b out_valid=%b zero=%b want 00000/0/1", sum, out_valid, zero);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL midreset_stale: out_valid cycles=%0d want 0", stale);
    end
  endtask

  task automatic test_random();
    logic [5:0] e;
    int m;
    int nv;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rs;
    nv = 0;
    for (int i = 0; i < 40 + LAT + 2; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL random: unexpected out_valid sum=%b", sum);
        end else begin
          e = exp_q.pop_front();
          if ({zero, sum} !== e) begin
            bad++;
            $display("FAIL random: zero,sum=%b want %b (a/b/sub)", {zero, sum}, e);
          end
        end
      end
      ra = 4'($urandom);
      rb = 4'($urandom);
      rs = 1'($urandom);
      a = ra;
      b = rb;
      sub = rs;
      if (i < 40 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        nv++;
        m = rs ? ((int'(ra) - int'(rb) + 32) % 32) : (int'(ra) + int'(rb));
        exp_q.push_back({(m == 0), 5'(m)});
      end else begin
        in_valid = 1'b0;
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_drain: %0d of %0d results missing, want 0", exp_q.size(), nv);
    end
    exp_q.delete();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_core.md
# adder_core

Registered unsigned adder/subtractor with a valid handshake. It serves as the datapath arithmetic block: two WIDTH-bit operands enter with `in_valid`, and a WIDTH+1-bit result leaves with `out_valid` after a fixed latency. The carry or borrow is kept as the result MSB, so no information is lost. The default WIDTH of 4 gives 4-bit operands and a 5-bit sum.

## Interface
- `WIDTH`, default 4: operand width in bits; must be ≥ 1.
- `clk`  input  1: rising-edge clock; the only clock.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: operands and `sub` are valid this cycle.
- `a`  input  WIDTH: operand A, unsigned.
- `b`  input  WIDTH: operand B, unsigned.
- `sub`  input  1: 0 computes A+B; 1 computes A−B.
- `sum`  output  WIDTH+1: result register.
- `out_valid`  output  1: `sum` holds a new result; high for exactly one cycle per accepted input.
- `zero`  output  1: registered flag, 1 when `sum == 0`.

## Operation
- Input is accepted on a rising `clk` edge where `in_valid` = 1. There is no backpressure: every valid input is accepted.
- Add (`sub` = 0): `sum = {1'b0, a} + {1'b0, b}`. `sum[WIDTH]` is the carry-out.
  - Example: 4'b1111 + 4'b0001 = 5'b10000.
- Subtract (`sub` = 1): `sum = {1'b0, a} − {1'b0, b}`, taken modulo 2^(WIDTH+1).
  - `sum[WIDTH]` = 1 exactly when b > a (borrow). The low bits are then the two's-complement wrap.
  - Example: 0 − 1 = 5'b11111.
- Both operands are zero-extended before the operation. No saturation is applied.
- `zero` is computed from the same result that is loaded into `sum`, and updates in the same cycle.
- On a cycle with `in_valid` = 0:
  - `sum` and `zero` hold their previous values.
  - `out_valid` deasserts on the next edge.
- Back-to-back valid inputs produce back-to-back results: one result per cycle, issued in order.

## Timing
- Reset (asynchronous assertion while `rst_n` = 0):
  - `sum` = 0
  - `out_valid` = 0
  - `zero` = 1
  - all internal pipeline valids = 0
- Reset release: the first input can be accepted at the first rising edge after `rst_n` rises.
- Latency (default build): 1 cycle. An input accepted at edge N gives `sum`, `zero` and `out_valid` = 1 visible after edge N.
- Throughput: 1 result per cycle.
- Reset asserted mid-operation: all in-flight results are discarded and no `out_valid` is issued for them. Outputs take their reset values immediately, without waiting for a clock edge.
- Boundary cases:
  - All-ones + all-ones = 2^(WIDTH+1) − 2; the carry is set.
  - A − A = 0 with `zero` = 1.
- Changes on `a`, `b` or `sub` while `in_valid` = 0 have no effect on any output.

## Configuration
- `ADDER_CORE_PIPE2_EN` defined:
  - An extra register stage is inserted. Operands and `sub` are registered first; the add/subtract result is registered on the following edge.
  - Latency is 2 cycles; throughput stays at 1 per cycle.
  - The in-flight valid bit and operands are also cleared by reset.
- `ADDER_CORE_PIPE2_EN` undefined: single-stage build with 1-cycle latency, as described in Timing.
- All other behaviour is identical in both builds, and the test plan values apply to both (allow 2 cycles of latency when the macro is defined).

## Test plan
- Reset: hold `rst_n` = 0 with random inputs and `in_valid` = 1 → `sum` = 5'b00000, `out_valid` = 0, `zero` = 1. Then release reset and feed a=0, b=0 → `sum` = 00000, `zero` = 1, `out_valid` pulses for one cycle.
- Add sequence, back-to-back with `sub` = 0: (1,2), (7,1), (15,1), (10,5) → `sum` = 00011, 01000, 10000, 01111 on consecutive cycles, with `out_valid` continuously high.
- Subtract with `sub` = 1:
  - 7−1 → 00110
  - 1−2 → 11111
  - 9−9 → 00000 with `zero` = 1
- Hold: after a valid 3+4 result, drive a=15, b=15 with `in_valid` = 0 for 5 cycles → `sum` stays 00111 and `out_valid` is 0 after the first cycle.
- Mid-stream reset: assert `rst_n` = 0 asynchronously between edges while a result is in flight → outputs reset immediately, and no stale `out_valid` appears after release.
- Extremes: 15+15 → 11110; 0−15 → 10001.
